// File: rtl/srcv_pkg.sv
// Shared definitions for the sample-rate scheduler.
//   sched_state_t : scheduler FSM states
//   buf_depth_ok  : elaboration-time legality check for the circular buffer length
package srcv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        ADV   = 3'd4
    } sched_state_t;

    // The buffer must hold at least two words and fit in the data-RAM address space.
    function automatic bit buf_depth_ok(input int depth, input int addr_w);
        return (depth >= 2) && (depth <= (1 << addr_w));
    endfunction

endpackage

// File: rtl/smpl_sched_wrptr.sv
// Circular write pointer for the scheduler's data buffer.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : advance the pointer by one word (wraps DEPTH-1 -> 0)
//   ptr      : address the next sample will be written to
//   prev     : address of the most recently written sample (ptr-1 modulo DEPTH)
module smpl_sched_wrptr #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W-1:0] prev
);

    // DEPTH need not be a power of two, so wrap explicitly at the last word.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

    assign prev = (ptr == '0) ? LAST : ptr - 1'b1;

endmodule

// File: rtl/smpl_sched.sv
// Sample-rate scheduler in front of the SRC controller.
// Accepts input samples over valid/ready, writes them into a circular buffer
// through data-RAM port A, and launches one controller run per output sample
// with the polyphase coefficient phase and the address of the newest sample.
// An L/M phase accumulator decides how many new inputs each output needs.
//   clk, rst              : clock, asynchronous active-low reset
//   en                    : run enable
//   cfg_l, cfg_m          : interpolation factor L, decimation factor M
//   s_valid/s_ready/s_data: input sample stream
//   ram_en/ram_wr/ram_addr/ram_wdata : data-RAM port A (writes only)
//   ctrl_start            : one-cycle pulse launching a controller run
//   ctrl_phase, ctrl_base : run arguments, stable from ctrl_start until ctrl_done
//   ctrl_done             : controller finished (single-cycle pulse)
//   busy                  : scheduler not idle
//   cfg_err               : sticky, zero L or M seen at run start
module smpl_sched
    import srcv_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DATA_ADDR_W = 6,
    parameter int BUF_DEPTH   = 64,
    parameter int RATIO_W     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [RATIO_W-1:0]     cfg_l,
    input  logic [RATIO_W-1:0]     cfg_m,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    output logic                   ram_en,
    output logic                   ram_wr,
    output logic [DATA_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
    output logic                   ctrl_start,
    output logic [RATIO_W-1:0]     ctrl_phase,
    output logic [DATA_ADDR_W-1:0] ctrl_base,
    input  logic                   ctrl_done,
    output logic                   busy,
    output logic                   cfg_err
);

    if (!buf_depth_ok(BUF_DEPTH, DATA_ADDR_W)) begin : g_bad_depth
        $error("smpl_sched: BUF_DEPTH must be in 2..2**DATA_ADDR_W");
    end

    localparam logic [RATIO_W:0] NEED_ONE = (RATIO_W + 1)'(1);

    sched_state_t state, state_nxt;

    logic [RATIO_W-1:0]     l_q, m_q;
    logic [RATIO_W-1:0]     phase;
    logic [RATIO_W:0]       acc;    // phase + M, one bit wider than the phase
    logic [RATIO_W:0]       need;   // samples still required before the next run
    logic [DATA_ADDR_W-1:0] base_q;
    logic [RATIO_W-1:0]     phase_q;
    logic [DATA_ADDR_W-1:0] wr_ptr, wr_prev;

    logic cfg_ok, take, last_take, acc_ge;

    assign cfg_ok    = (cfg_l != '0) && (cfg_m != '0);
    assign take      = (state == FILL) && s_valid;   // s_ready is 1 throughout FILL
    assign last_take = take && (need == NEED_ONE);
    assign acc_ge    = (acc >= {1'b0, l_q});

    smpl_sched_wrptr #(
        .ADDR_W (DATA_ADDR_W),
        .DEPTH  (BUF_DEPTH)
    ) u_wrptr (
        .clk  (clk),
        .rst  (rst),
        .inc  (take),
        .ptr  (wr_ptr),
        .prev (wr_prev)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state. Dropping en only takes effect in FILL/ADV; an issued run is
    // always allowed to complete before returning to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && cfg_ok) state_nxt = FILL;
            FILL: begin
                if (!en)            state_nxt = IDLE;
                else if (last_take) state_nxt = START;
            end
            START:   state_nxt = WAIT;   // a ctrl_done here belongs to no run of ours
            WAIT:    if (ctrl_done) state_nxt = en ? ADV : IDLE;
            ADV: begin
                if (!en)          state_nxt = IDLE;
                else if (!acc_ge) state_nxt = (need == '0) ? START : FILL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration, phase accumulator and run-argument holding registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l_q     <= '0;
            m_q     <= '0;
            phase   <= '0;
            acc     <= '0;
            need    <= NEED_ONE;
            base_q  <= '0;
            phase_q <= '0;
            cfg_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        if (cfg_ok) begin
                            l_q     <= cfg_l;
                            m_q     <= cfg_m;
                            phase   <= '0;
                            need    <= NEED_ONE;
                            cfg_err <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (take) need <= need - 1'b1;
                end
                START: begin
                    base_q  <= wr_prev;
                    phase_q <= phase;
                end
                WAIT: begin
                    if (ctrl_done && en) begin
                        acc  <= {1'b0, phase} + {1'b0, m_q};
                        need <= '0;
                    end
                end
                ADV: begin
                    // Serial divide of (phase+M) by L: each subtraction is one more input.
                    if (acc_ge) begin
                        acc  <= acc - {1'b0, l_q};
                        need <= need + 1'b1;
                    end else begin
                        phase <= acc[RATIO_W-1:0];   // acc < L here, so it fits
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs. Run arguments are driven live during START and held afterwards.
    always_comb begin
        s_ready    = (state == FILL);
        ram_en     = take;
        ram_wr     = take;
        ram_addr   = take ? wr_ptr : '0;
        ram_wdata  = take ? s_data : '0;
        ctrl_start = (state == START);
        ctrl_phase = (state == START) ? phase : phase_q;
        ctrl_base  = (state == START) ? wr_prev : base_q;
        busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_smpl_sched.sv
module tb_smpl_sched;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic run_en, sel, en_a, en_b;
    logic [RW-1:0] cfg_l, cfg_m;
    logic s_valid, ctrl_done;
    logic [DW-1:0] s_data;

    assign en_a = run_en & ~sel;
    assign en_b = run_en & sel;

    logic s_ready_a, ram_en_a, ram_wr_a, ctrl_start_a, busy_a, cfg_err_a;
    logic [AW-1:0] ram_addr_a, ctrl_base_a;
    logic [DW-1:0] ram_wdata_a;
    logic [RW-1:0] ctrl_phase_a;
    logic s_ready_b, ram_en_b, ram_wr_b, ctrl_start_b, busy_b, cfg_err_b;
    logic [AW-1:0] ram_addr_b, ctrl_base_b;
    logic [DW-1:0] ram_wdata_b;
    logic [RW-1:0] ctrl_phase_b;

    smpl_sched #(.DATA_W(DW), .DATA_ADDR_W(AW), .BUF_DEPTH(64), .RATIO_W(RW)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .cfg_l(cfg_l), .cfg_m(cfg_m),
        .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
        .ram_en(ram_en_a), .ram_wr(ram_wr_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
        .ctrl_start(ctrl_start_a), .ctrl_phase(ctrl_phase_a), .ctrl_base(ctrl_base_a),
        .ctrl_done(ctrl_done), .busy(busy_a), .cfg_err(cfg_err_a));

    smpl_sched #(.DATA_W(DW), .DATA_ADDR_W(AW), .BUF_DEPTH(6), .RATIO_W(RW)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .cfg_l(cfg_l), .cfg_m(cfg_m),
        .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .ram_en(ram_en_b), .ram_wr(ram_wr_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
        .ctrl_start(ctrl_start_b), .ctrl_phase(ctrl_phase_b), .ctrl_base(ctrl_base_b),
        .ctrl_done(ctrl_done), .busy(busy_b), .cfg_err(cfg_err_b));

    // View of whichever instance the current case targets
    logic m_s_ready, m_ram_en, m_ram_wr, m_ctrl_start, m_busy, m_cfg_err;
    logic [AW-1:0] m_ram_addr, m_ctrl_base;
    logic [DW-1:0] m_ram_wdata;
    logic [RW-1:0] m_ctrl_phase;
    always_comb begin
        m_s_ready    = sel ? s_ready_b    : s_ready_a;
        m_ram_en     = sel ? ram_en_b     : ram_en_a;
        m_ram_wr     = sel ? ram_wr_b     : ram_wr_a;
        m_ram_addr   = sel ? ram_addr_b   : ram_addr_a;
        m_ram_wdata  = sel ? ram_wdata_b  : ram_wdata_a;
        m_ctrl_start = sel ? ctrl_start_b : ctrl_start_a;
        m_ctrl_phase = sel ? ctrl_phase_b : ctrl_phase_a;
        m_ctrl_base  = sel ? ctrl_base_b  : ctrl_base_a;
        m_busy       = sel ? busy_b       : busy_a;
        m_cfg_err    = sel ? cfg_err_b    : cfg_err_a;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One scenario: which DUT, L, M, number of runs, expected per-run
    // (base offset from the starting write pointer, phase).
    typedef struct packed {
        logic           sel;
        logic [4:0]     l;
        logic [4:0]     m;
        logic [3:0]     n;
        logic [7:0][5:0] off;
        logic [7:0][4:0] ph;
    } vec_t;

    function automatic vec_t mk(input logic s, input int l, input int m, input int n,
                                input logic [7:0][5:0] off, input logic [7:0][4:0] ph);
        vec_t v;
        v.sel = s; v.l = 5'(l); v.m = 5'(m); v.n = 4'(n); v.off = off; v.ph = ph;
        return v;
    endfunction

    // Output k sits at input time k*M/L: it uses input floor(k*M/L) as its
    // newest sample and coefficient phase (k*M) mod L.
    function automatic vec_t model_row(input logic s, input int l, input int m, input int n);
        vec_t v;
        v.sel = s; v.l = 5'(l); v.m = 5'(m); v.n = 4'(n); v.off = '0; v.ph = '0;
        for (int k = 0; k < n; k++) begin
            v.off[k] = 6'((k * m) / l);
            v.ph[k]  = 5'((k * m) % l);
        end
        return v;
    endfunction

    int mp[2];                    // next expected write address per DUT
    int depth[2] = '{64, 6};

    task automatic run_case(input int idx, input vec_t v);
        int fed, starts, cd, need_total, base0, d, s;
        logic acc, st, fin;
        s = int'(v.sel);
        d = depth[s];
        base0 = mp[s];
        need_total = ((int'(v.n) - 1) * int'(v.m)) / int'(v.l) + 1;
        fed = 0; starts = 0; cd = -1; fin = 1'b0;
        sel = v.sel; cfg_l = v.l; cfg_m = v.m;
        s_valid = 1'b0; ctrl_done = 1'b0; run_en = 1'b1;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            acc = s_valid & m_s_ready;
            st  = m_ctrl_start;
            chk("ram_en", m_ram_en, acc);
            if (acc) begin
                chk("ram_wr", m_ram_wr, 1);
                chk("ram_addr", m_ram_addr, mp[s]);
                chk("ram_wdata", m_ram_wdata, s_data);
            end
            if (cd >= 0) chk("ready_in_wait", m_s_ready, 0);
            if (st) begin
                if (starts < int'(v.n)) begin
                    chk($sformatf("ctrl_base c%0d r%0d", idx, starts), m_ctrl_base,
                        (base0 + int'(v.off[starts])) % d);
                    chk($sformatf("ctrl_phase c%0d r%0d", idx, starts), m_ctrl_phase,
                        int'(v.ph[starts]));
                    chk($sformatf("inputs_before_run c%0d r%0d", idx, starts), fed,
                        (starts * int'(v.m)) / int'(v.l) + 1);
                end else begin
                    chk($sformatf("extra_start c%0d", idx), starts + 1, int'(v.n));
                end
                starts++;
                cd = 4 + $urandom_range(0, 3);
                if ($urandom_range(0, 1) == 1) ctrl_done = 1'b1;   // lands in START, must be ignored
            end
            @(posedge clk); #1;
            if (acc) begin
                fed++;
                mp[s] = (mp[s] + 1) % d;
            end
            ctrl_done = 1'b0;
            if (cd > 0) cd--;
            else if (cd == 0) begin
                ctrl_done = 1'b1;
                cd = -1;
                if (starts >= int'(v.n)) fin = 1'b1;
            end
            if (starts >= int'(v.n)) run_en = 1'b0;   // drop en while the last run is in WAIT
            s_valid = (fed < need_total) && ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
        end
        if (!fin) chk($sformatf("timeout c%0d", idx), 0, 1);
        @(posedge clk); #1;
        ctrl_done = 1'b0;
        s_valid   = 1'b0;
        chk($sformatf("run_count c%0d", idx), starts, int'(v.n));
        repeat (3) begin
            @(negedge clk);
            chk("after_busy", m_busy, 0);
            chk("after_start", m_ctrl_start, 0);
            chk("after_ready", m_s_ready, 0);
        end
    endtask

    vec_t tbl[12];

    initial begin
        rst = 1'b0; run_en = 1'b1; sel = 1'b0; cfg_l = 5'd1; cfg_m = 5'd1;
        s_valid = 1'b0; s_data = '0; ctrl_done = 1'b0;
        mp[0] = 0; mp[1] = 0;

        // Reset held with en=1: everything quiet
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready_a, 0);
        chk("rst_ram_en", ram_en_a, 0);
        chk("rst_ram_wr", ram_wr_a, 0);
        chk("rst_ram_addr", ram_addr_a, 0);
        chk("rst_ram_wdata", ram_wdata_a, 0);
        chk("rst_ctrl_start", ctrl_start_a, 0);
        chk("rst_ctrl_phase", ctrl_phase_a, 0);
        chk("rst_ctrl_base", ctrl_base_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_cfg_err", cfg_err_a, 0);
        chk("rst_busy_b", busy_b, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy_a, 1);
        chk("post_rst_s_ready", s_ready_a, 1);
        run_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("fill_en_drop_busy", busy_a, 0);

        tbl[0]  = mk(0, 1, 1, 4, {6'd0,6'd0,6'd0,6'd0,6'd3,6'd2,6'd1,6'd0}, '0);
        tbl[1]  = mk(0, 3, 1, 3, '0, {5'd0,5'd0,5'd0,5'd0,5'd0,5'd2,5'd1,5'd0});
        tbl[2]  = mk(0, 2, 3, 5, {6'd0,6'd0,6'd0,6'd6,6'd4,6'd3,6'd1,6'd0},
                                 {5'd0,5'd0,5'd0,5'd0,5'd1,5'd0,5'd1,5'd0});
        tbl[3]  = mk(1, 1, 1, 7, {6'd0,6'd6,6'd5,6'd4,6'd3,6'd2,6'd1,6'd0}, '0);
        tbl[4]  = mk(0, 1, 3, 3, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd6,6'd3,6'd0}, '0);
        tbl[5]  = mk(0, 31, 30, 2, '0, {5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd30,5'd0});
        tbl[6]  = mk(0, 1, 31, 2, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd31,6'd0}, '0);
        for (int i = 7; i < 11; i++)
            tbl[i] = model_row(0, $urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8));
        tbl[11] = model_row(1, $urandom_range(1, 5), $urandom_range(1, 5), 8);

        for (int i = 0; i < 12; i++) run_case(i, tbl[i]);

        // Zero L or M at run start: sticky error, stays idle; a valid start clears it
        sel = 1'b0; cfg_l = 5'd0; cfg_m = 5'd1; run_en = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("cfg_l0_err", cfg_err_a, 1);
        chk("cfg_l0_busy", busy_a, 0);
        chk("cfg_l0_ready", s_ready_a, 0);
        cfg_l = 5'd3; cfg_m = 5'd0;
        @(negedge clk);
        chk("cfg_m0_err", cfg_err_a, 1);
        chk("cfg_m0_busy", busy_a, 0);
        cfg_l = 5'd2; cfg_m = 5'd1;
        @(negedge clk);
        chk("cfg_ok_err_clr", cfg_err_a, 0);
        chk("cfg_ok_busy", busy_a, 1);
        run_en = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("cfg_end_busy", busy_a, 0);
        chk("cfg_end_err", cfg_err_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
